vmac_sequencer: RTL and testbench
=================================

// Module: vmac_sequencer
// PURPOSE
//  Multi-cycle issue/sequencing controller for the packed-SIMD VMAC unit (opcode 0x5B, funct3 001).
//  Accepts one decoded VMAC op (op = vmac_ctrl) with operands from the register file.
//  Time-multiplexes a small pool of signed lane multipliers across all lanes.
//  Returns the packed result to writeback over a valid/ready handshake; busy stalls the front end.
// PARAMETERS
//  XLEN           32  datapath/register width
//  LANES          4   packed lanes per register; LANE_W = XLEN/LANES (localparam)
//  MULS_PER_CYCLE 1   lanes multiplied per EXEC cycle; must divide LANES; NCYC = LANES/MULS_PER_CYCLE
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  issue_valid  in   1     decoder presents a VMAC op (is_vmac)
//  issue_ready  out  1     sequencer can accept an op
//  issue_op     in   2     00 PVADD, 01 PVMUL, 10 PVMAC, 11 PVMUL_UPPER
//  issue_rd     in   5     destination register
//  src_a        in   XLEN  rs1 value
//  src_b        in   XLEN  rs2 value
//  src_c        in   XLEN  current rd value (accumulator, used by PVMAC only)
//  flush        in   1     synchronous abort of the in-flight op
//  wb_valid     out  1     result available
//  wb_ready     in   1     writeback accepts result
//  wb_rd        out  5     destination register of result
//  wb_data      out  XLEN  packed result
//  busy         out  1     state != IDLE; front-end stall request
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, lane counter=0, result/operand regs=0; wb_valid=0, wb_rd=0,
//   wb_data=0, busy=0, issue_ready=1. Reset mid-operation discards the op; nothing is written back.
//  States IDLE, EXEC, DONE. issue_ready = (state==IDLE). Accept = issue_valid & issue_ready (cycle 0):
//   latch op, rd, a, b, c; PVADD -> DONE; other ops -> EXEC with counter=0.
//  EXEC: each cycle compute MULS_PER_CYCLE lanes starting at lane index counter*MULS_PER_CYCLE
//   (lane 0 = bits LANE_W-1:0); write their fields into result reg; counter++;
//   after the NCYC-th cycle -> DONE. Latency: wb_valid rises cycle 1 (PVADD), cycle NCYC+1 otherwise.
//  DONE: wb_valid=1; wb_data/wb_rd stable until wb_valid&wb_ready; then -> IDLE next cycle.
//   No new issue is accepted in the cycle of the handshake (one bubble between ops).
//  Lane arithmetic (operands signed two's complement, LANE_W bits; product 2*LANE_W bits):
//   PVADD: a_i+b_i mod 2^LANE_W. PVMUL: low LANE_W bits of a_i*b_i.
//   PVMUL_UPPER: high LANE_W bits of signed a_i*b_i. PVMAC: c_i + low(a_i*b_i) mod 2^LANE_W.
//   No saturation, no carry between lanes, no flags.
//  flush: any state -> IDLE next cycle, wb_valid=0 next cycle; flush has priority over issue and over
//   a same-cycle wb handshake (result dropped). flush in IDLE is a no-op; issue that cycle is refused.
//  rd=0 is carried unchanged; the register file discards x0 writes.
//  issue_valid while busy is held by the decoder; issue_* are sampled only on accept.
// STRUCTURE
//  Package vmac_pkg: op encodings VMAC_PVADD/PVMUL/PVMAC/PVMUL_UPPER, state enum, opcode 0x5B/funct3 001.
//  Sub-module vmac_lane_mul: combinational signed LANE_W x LANE_W -> 2*LANE_W multiplier,
//   instantiated MULS_PER_CYCLE times; lane select muxes and FSM stay in vmac_sequencer.
// TESTING (LANES=4, MULS_PER_CYCLE=1, wb_ready=1 unless stated)
//  PVADD a=7F01FF10 b=01010102 -> wb_data=80020012 at cycle 1; busy 1 cycle; wb_rd echoes issue_rd.
//  PVMUL a=02FF0310 b=03020405 -> wb_data=06FE0C50, wb_valid first at cycle 5.
//  PVMUL_UPPER a=80807F01 b=80017F01 -> wb_data=40FF3F00; PVMAC c=01020304 a=02020202 b=03030303
//   -> 0708090A; c=FF000000 a=01000000 b=01000000 -> 00000000 (lane wrap).
//  wb_ready=0 for 3 cycles in DONE -> wb_valid, wb_data stable, issue_ready=0; IDLE one cycle after accept.
//  flush at cycle 2 of PVMUL -> IDLE at cycle 3, no wb_valid; flush+issue_valid in IDLE -> not accepted.
//  rst_n low mid-EXEC -> all outputs at reset values immediately (async); next op after release correct.

Source files
------------

// File: rtl/vmac_pkg.sv
// Shared definitions for the packed-SIMD VMAC unit: instruction encoding,
// lane operation codes and the sequencer state type.
package vmac_pkg;

    localparam logic [6:0] VMAC_OPCODE = 7'h5B;
    localparam logic [2:0] VMAC_FUNCT3 = 3'b001;

    typedef enum logic [1:0] {
        VMAC_PVADD       = 2'b00,
        VMAC_PVMUL       = 2'b01,
        VMAC_PVMAC       = 2'b10,
        VMAC_PVMUL_UPPER = 2'b11
    } vmac_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } vmac_state_t;

endpackage

// File: rtl/vmac_lane_mul.sv
// Combinational signed LANE_W x LANE_W multiplier producing the full
// 2*LANE_W-bit product; one instance per lane multiplied per EXEC cycle.
module vmac_lane_mul #(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0]   a,
    input  logic [LANE_W-1:0]   b,
    output logic [2*LANE_W-1:0] prod
);

    logic [2*LANE_W-1:0] a_ext;
    logic [2*LANE_W-1:0] b_ext;

    // Sign-extend both operands to the product width so the truncated
    // unsigned multiply yields the exact two's complement product.
    always_comb begin
        a_ext = {{LANE_W{a[LANE_W-1]}}, a};
        b_ext = {{LANE_W{b[LANE_W-1]}}, b};
        prod  = a_ext * b_ext;
    end

endmodule

// File: rtl/vmac_sequencer.sv
// Multi-cycle issue/sequencing controller for the packed-SIMD VMAC unit.
// Accepts one decoded op, time-multiplexes MULS_PER_CYCLE lane multipliers
// across all lanes, and hands the packed result to writeback.
module vmac_sequencer
    import vmac_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int LANES          = 4,
    parameter int MULS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [1:0]      issue_op,
    input  logic [4:0]      issue_rd,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [XLEN-1:0] src_c,
    input  logic            flush,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy
);

    localparam int LANE_W = XLEN / LANES;
    localparam int NCYC   = LANES / MULS_PER_CYCLE;
    localparam int CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    vmac_state_t state;
    vmac_state_t state_next;
    logic        accept;

    logic [CNT_W-1:0] cnt;
    vmac_op_t         op_reg;
    logic [4:0]       rd_reg;

    logic [LANE_W-1:0] a_in    [LANES];
    logic [LANE_W-1:0] b_in    [LANES];
    logic [LANE_W-1:0] c_in    [LANES];
    logic [LANE_W-1:0] a_reg   [LANES];
    logic [LANE_W-1:0] b_reg   [LANES];
    logic [LANE_W-1:0] c_reg   [LANES];
    logic [LANE_W-1:0] res_reg [LANES];

    logic [LIDX_W-1:0]   sel_idx  [MULS_PER_CYCLE];
    logic [LANE_W-1:0]   mul_a    [MULS_PER_CYCLE];
    logic [LANE_W-1:0]   mul_b    [MULS_PER_CYCLE];
    logic [LANE_W-1:0]   mul_c    [MULS_PER_CYCLE];
    logic [2*LANE_W-1:0] prod     [MULS_PER_CYCLE];
    logic [LANE_W-1:0]   lane_res [MULS_PER_CYCLE];

    // Lane 0 occupies the least significant LANE_W bits of every packed word.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign a_in[i] = src_a[i*LANE_W +: LANE_W];
        assign b_in[i] = src_b[i*LANE_W +: LANE_W];
        assign c_in[i] = src_c[i*LANE_W +: LANE_W];
        assign wb_data[i*LANE_W +: LANE_W] = res_reg[i];
    end

    for (genvar m = 0; m < MULS_PER_CYCLE; m++) begin : g_mul
        vmac_lane_mul #(
            .LANE_W (LANE_W)
        ) u_lane_mul (
            .a    (mul_a[m]),
            .b    (mul_b[m]),
            .prod (prod[m])
        );
    end

    assign wb_rd = rd_reg;

    // State register; reset abandons any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; flush overrides everything and also
    // masks wb_valid so a same-cycle writeback handshake cannot complete.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        issue_ready = (state == ST_IDLE);
        busy        = (state != ST_IDLE);
        wb_valid    = (state == ST_DONE) && !flush;
        case (state)
            ST_IDLE: begin
                if (issue_valid && !flush) begin
                    accept     = 1'b1;
                    state_next = (vmac_op_t'(issue_op) == VMAC_PVADD) ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == CNT_W'(NCYC - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (wb_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    // Select this cycle's lanes for the multipliers and form each lane result.
    always_comb begin
        for (int m = 0; m < MULS_PER_CYCLE; m++) begin
            sel_idx[m] = LIDX_W'(int'(cnt) * MULS_PER_CYCLE + m);
            mul_a[m]   = a_reg[sel_idx[m]];
            mul_b[m]   = b_reg[sel_idx[m]];
            mul_c[m]   = c_reg[sel_idx[m]];
            case (op_reg)
                VMAC_PVMUL:       lane_res[m] = prod[m][LANE_W-1:0];
                VMAC_PVMUL_UPPER: lane_res[m] = prod[m][2*LANE_W-1:LANE_W];
                VMAC_PVMAC:       lane_res[m] = mul_c[m] + prod[m][LANE_W-1:0];
                default:          lane_res[m] = mul_a[m] + mul_b[m];
            endcase
        end
    end

    // Operand capture on accept (PVADD completes all lanes at once), then
    // one group of lanes written back into the result register per EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_reg <= VMAC_PVADD;
            rd_reg <= '0;
            for (int i = 0; i < LANES; i++) begin
                a_reg[i]   <= '0;
                b_reg[i]   <= '0;
                c_reg[i]   <= '0;
                res_reg[i] <= '0;
            end
        end else if (accept) begin
            cnt    <= '0;
            op_reg <= vmac_op_t'(issue_op);
            rd_reg <= issue_rd;
            for (int i = 0; i < LANES; i++) begin
                a_reg[i] <= a_in[i];
                b_reg[i] <= b_in[i];
                c_reg[i] <= c_in[i];
                if (vmac_op_t'(issue_op) == VMAC_PVADD) begin
                    res_reg[i] <= a_in[i] + b_in[i];
                end
            end
        end else if (state == ST_EXEC && !flush) begin
            for (int m = 0; m < MULS_PER_CYCLE; m++) begin
                res_reg[sel_idx[m]] <= lane_res[m];
            end
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vmac_sequencer.sv
// Directed self-checking bench for vmac_sequencer (LANES=4, one multiplier).
module tb_vmac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [1:0]  issue_op = 2'b00;
    logic [4:0]  issue_rd = 5'd0;
    logic [31:0] src_a = 32'h0;
    logic [31:0] src_b = 32'h0;
    logic [31:0] src_c = 32'h0;
    logic        flush = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    logic seen;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_MAC = 2'b10;
    localparam logic [1:0] OP_MULU = 2'b11;

    vmac_sequencer #(
        .XLEN           (32),
        .LANES          (4),
        .MULS_PER_CYCLE (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .src_a       (src_a),
        .src_b       (src_b),
        .src_c       (src_c),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one op for a single cycle; called #1 after a rising edge.
    task automatic issueOp(input logic [1:0] op, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rd    = rd;
        src_a       = a;
        src_b       = b;
        src_c       = c;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    // Wait for wb_valid with a bounded cycle budget; lat counts from the accept cycle.
    task automatic waitValid(output int cycles);
        cycles = 1;
        while (wb_valid !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Full op: issue, check latency, result and rd, then complete the handshake.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                 input logic [31:0] exp_data, input int exp_lat);
        int l;
        checkOutput({tag, " issue_ready"}, {31'b0, issue_ready}, 32'd1);
        issueOp(op, rd, a, b, c);
        waitValid(l);
        checkOutput({tag, " latency"}, l, exp_lat);
        checkOutput({tag, " wb_data"}, wb_data, exp_data);
        checkOutput({tag, " wb_rd"}, {27'b0, wb_rd}, {27'b0, rd});
        @(posedge clk);
        #1;
        checkOutput({tag, " busy after wb"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        // Reset values while rst_n is low.
        #1;
        checkOutput("reset wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("reset wb_rd", {27'b0, wb_rd}, 32'd0);
        checkOutput("reset wb_data", wb_data, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset issue_ready", {31'b0, issue_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic vectors.
        applyStimulus("pvadd", OP_ADD, 5'd3, 32'h7F01FF10, 32'h01010102, 32'h0, 32'h80020012, 1);
        applyStimulus("pvmul", OP_MUL, 5'd17, 32'h02FF0310, 32'h03020405, 32'h0, 32'h06FE0C50, 5);
        applyStimulus("pvmulu", OP_MULU, 5'd31, 32'h80807F01, 32'h80017F01, 32'h0, 32'h40FF3F00, 5);
        applyStimulus("pvmulu2", OP_MULU, 5'd4, 32'h7F020304, 32'h80FD0506, 32'h0, 32'hC0FF0000, 5);
        applyStimulus("pvmac", OP_MAC, 5'd5, 32'h02020202, 32'h03030303, 32'h01020304, 32'h0708090A, 5);
        applyStimulus("pvmac wrap", OP_MAC, 5'd6, 32'h01000000, 32'h01000000, 32'hFF000000, 32'h00000000, 5);
        applyStimulus("pvmac neg", OP_MAC, 5'd0, 32'hFF02FE80, 32'h02FF0302, 32'h10203040, 32'h0E1E2A40, 5);

        // Writeback back-pressure: result held stable, no new issue possible.
        wb_ready = 1'b0;
        issueOp(OP_MUL, 5'd9, 32'h02FF0310, 32'h03020405, 32'h0);
        waitValid(lat);
        checkOutput("stall latency", lat, 32'd5);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("stall wb_valid", {31'b0, wb_valid}, 32'd1);
            checkOutput("stall wb_data", wb_data, 32'h06FE0C50);
            checkOutput("stall issue_ready", {31'b0, issue_ready}, 32'd0);
        end
        // Handshake cycle with a waiting op: it must see one bubble first.
        wb_ready    = 1'b1;
        issue_valid = 1'b1;
        issue_op    = OP_ADD;
        issue_rd    = 5'd12;
        src_a       = 32'h00000001;
        src_b       = 32'h00000002;
        @(posedge clk);
        #1;
        checkOutput("bubble busy", {31'b0, busy}, 32'd0);
        checkOutput("bubble issue_ready", {31'b0, issue_ready}, 32'd1);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        checkOutput("after bubble wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("after bubble wb_data", wb_data, 32'h00000003);
        checkOutput("after bubble wb_rd", {27'b0, wb_rd}, 32'd12);
        @(posedge clk);
        #1;

        // Flush in cycle 2 of a PVMUL: idle at cycle 3 and no result ever.
        issueOp(OP_MUL, 5'd8, 32'h02FF0310, 32'h03020405, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush busy", {31'b0, busy}, 32'd0);
        checkOutput("flush issue_ready", {31'b0, issue_ready}, 32'd1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (wb_valid) seen = 1'b1;
        end
        checkOutput("flush no wb_valid", {31'b0, seen}, 32'd0);

        // Flush together with issue in IDLE: op refused.
        flush = 1'b1;
        issueOp(OP_ADD, 5'd2, 32'h11111111, 32'h11111111, 32'h0);
        flush = 1'b0;
        checkOutput("flush+issue busy", {31'b0, busy}, 32'd0);
        checkOutput("flush+issue wb_valid", {31'b0, wb_valid}, 32'd0);

        // Flush in DONE drops the pending result.
        wb_ready = 1'b0;
        issueOp(OP_ADD, 5'd7, 32'h01010101, 32'h01010101, 32'h0);
        checkOutput("done wb_valid", {31'b0, wb_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        wb_ready = 1'b1;
        checkOutput("done flush wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("done flush busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of EXEC.
        issueOp(OP_MUL, 5'd21, 32'h02FF0310, 32'h03020405, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst busy", {31'b0, busy}, 32'd0);
        checkOutput("async rst issue_ready", {31'b0, issue_ready}, 32'd1);
        checkOutput("async rst wb_data", wb_data, 32'd0);
        checkOutput("async rst wb_rd", {27'b0, wb_rd}, 32'd0);
        checkOutput("async rst wb_valid", {31'b0, wb_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("post rst pvmac", OP_MAC, 5'd13, 32'h02020202, 32'h03030303, 32'h01020304, 32'h0708090A, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
